// File: rtl/kd_pkg.sv
// Shared definitions for the kd-tree parent/child command link.
// Holds the bus widths, the command encodings both sides of the link agree
// on, the sort-axis encodings, and the leaf state encoding.
package kd_pkg;

    localparam int COMMAND_SIZE = 5;
    localparam int DATA_SIZE    = 24;
    localparam int CH_SIZE      = 8;

    // Command codes travelling down (parent -> child) and up (child -> parent)
    localparam logic [COMMAND_SIZE-1:0] CMD_NOP                      = 5'h00;
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL              = 5'h01;
    localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS      = 5'h02;
    localparam logic [COMMAND_SIZE-1:0] CMD_RECEIVE_CENTER           = 5'h03;
    localparam logic [COMMAND_SIZE-1:0] CMD_SWITCH_WITH_LEFT         = 5'h04;
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL_DONE         = 5'h05;
    localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'h07;
    localparam logic [COMMAND_SIZE-1:0] CMD_BUSY                     = 5'h08;
    localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING            = 5'h09;
    localparam logic [COMMAND_SIZE-1:0] CMD_SWITCH                   = 5'h0b;
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_SORT               = 5'h0f;
    localparam logic [COMMAND_SIZE-1:0] CMD_DNE                      = 5'h10;
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_DONE               = 5'h11;
    localparam logic [COMMAND_SIZE-1:0] CMD_EXPOSE_CENTER            = 5'h12;
    localparam logic [COMMAND_SIZE-1:0] CMD_NEXT_SORT_LEVEL          = 5'h13;
    localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING_AS_ROOT    = 5'h14;
    localparam logic [COMMAND_SIZE-1:0] CMD_SORT_DONE                = 5'h15;
    localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE                 = 5'h1e;
    localparam logic [COMMAND_SIZE-1:0] CMD_RST                      = 5'h1f;

    // Sort axis selects one colour channel; 2'd3 is never stored
    localparam logic [1:0] AXIS_R       = 2'd0;
    localparam logic [1:0] AXIS_G       = 2'd1;
    localparam logic [1:0] AXIS_B       = 2'd2;
    localparam logic [1:0] AXIS_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FULL   = 2'd1,
        ST_SORTED = 2'd2
    } leaf_state_t;

endpackage

// File: rtl/kd_axis_select.sv
// Combinational channel mux: picks the colour channel of a center that the
// current sort axis refers to.
// Ports:
//   center  in  DATA_SIZE  RGB center (R=[23:16], G=[15:8], B=[7:0])
//   axis    in  2          sort axis (0=R, 1=G, 2=B)
//   key     out CH_SIZE    selected channel
module kd_axis_select
    import kd_pkg::*;
(
    input  logic [DATA_SIZE-1:0] center,
    input  logic [1:0]           axis,
    output logic [CH_SIZE-1:0]   key
);

    // The illegal axis value never reaches storage, so it just maps to zero
    always_comb begin
        key = '0;
        case (axis)
            AXIS_R:  key = center[23:16];
            AXIS_G:  key = center[15:8];
            AXIS_B:  key = center[7:0];
            default: key = '0;
        endcase
    end

endmodule

// File: rtl/kd_leaf_responder.sv
// Leaf endpoint of the kd-tree parent/child link. It stands in for an empty
// subtree under a node, holds a single RGB center, and answers every parent
// command with a registered status/data response one cycle later.
// Ports:
//   clk               in   1             rising-edge clock
//   reset             in   1             synchronous active-low reset
//   command_from_top  in   COMMAND_SIZE  command from the parent
//   data_from_top     in   DATA_SIZE     data from the parent
//   command_to_top    out  COMMAND_SIZE  registered status to the parent
//   data_to_top       out  DATA_SIZE     registered data to the parent
//   key_to_top        out  CH_SIZE       registered channel of center on axis
//   occupied          out  1             registered: a center is held
module kd_leaf_responder
    import kd_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COMMAND_SIZE-1:0] command_from_top,
    input  logic [DATA_SIZE-1:0]    data_from_top,
    output logic [COMMAND_SIZE-1:0] command_to_top,
    output logic [DATA_SIZE-1:0]    data_to_top,
    output logic [CH_SIZE-1:0]      key_to_top,
    output logic                    occupied
);

    leaf_state_t             state, state_next;
    logic [DATA_SIZE-1:0]    center, center_next;
    logic [1:0]              axis, axis_next;
    logic [COMMAND_SIZE-1:0] command_next;
    logic [DATA_SIZE-1:0]    data_next;
    logic                    occupied_next;
    logic [CH_SIZE-1:0]      key_next;

    // The key is computed from the values the center and axis are about to
    // take, so it lands in the same cycle as the response that changed them.
    kd_axis_select u_axis_select (
        .center (center_next),
        .axis   (axis_next),
        .key    (key_next)
    );

    // State, storage and all up-link outputs are registered together; reset
    // wins over any command presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            center         <= '0;
            axis           <= AXIS_R;
            occupied       <= 1'b0;
            command_to_top <= CMD_NOP;
            data_to_top    <= '0;
            key_to_top     <= '0;
        end else begin
            state          <= state_next;
            center         <= center_next;
            axis           <= axis_next;
            occupied       <= occupied_next;
            command_to_top <= command_next;
            data_to_top    <= data_next;
            key_to_top     <= key_next;
        end
    end

    // Command decode. Everything holds by default and the response code falls
    // back to nop, which also covers unknown codes.
    always_comb begin
        state_next    = state;
        center_next   = center;
        axis_next     = axis;
        occupied_next = occupied;
        command_next  = CMD_NOP;
        data_next     = data_to_top;

        case (command_from_top)
            CMD_RST: begin
                state_next    = ST_IDLE;
                center_next   = '0;
                axis_next     = AXIS_R;
                occupied_next = 1'b0;
                command_next  = CMD_RST_DONE;
                data_next     = '0;
            end
            CMD_CENTER_FILL: begin
                // A full leaf reports done so the parent steers fills elsewhere
                if (state == ST_IDLE) begin
                    state_next    = ST_FULL;
                    center_next   = data_from_top;
                    occupied_next = 1'b1;
                    command_next  = CMD_RECEIVE_CENTER;
                end else begin
                    command_next  = CMD_CENTER_FILL_DONE;
                end
            end
            CMD_CONFIGURE_SORT_AXIS: begin
                if (data_from_top[1:0] == AXIS_ILLEGAL) begin
                    command_next = CMD_DNE;
                end else begin
                    axis_next    = data_from_top[1:0];
                    command_next = CMD_CONFIGURE_SORT_AXIS_DONE;
                end
            end
            CMD_EXPOSE_CENTER: begin
                if (occupied) begin
                    data_next    = center;
                    command_next = CMD_VALID_SORT;
                end else begin
                    data_next    = '0;
                    command_next = CMD_DNE;
                end
            end
            CMD_SWITCH, CMD_SWITCH_WITH_LEFT: begin
                // True swap: the old center goes up while the new one is stored
                if (occupied) begin
                    state_next   = ST_FULL;
                    center_next  = data_from_top;
                    data_next    = center;
                    command_next = CMD_VALID_DONE;
                end else begin
                    command_next = CMD_DNE;
                end
            end
            CMD_START_SORTING, CMD_START_SORTING_AS_ROOT, CMD_NEXT_SORT_LEVEL: begin
                // A single element is already sorted
                state_next   = occupied ? ST_SORTED : ST_IDLE;
                command_next = CMD_SORT_DONE;
            end
            default: begin
                command_next = CMD_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_kd_leaf_responder.sv
// Self-checking bench for kd_leaf_responder: directed scenarios followed by a
// randomized command stream, all checked against a behavioural leaf model.
module tb_kd_leaf_responder;
    import kd_pkg::*;

    logic                    clk;
    logic                    reset;
    logic [COMMAND_SIZE-1:0] command_from_top;
    logic [DATA_SIZE-1:0]    data_from_top;
    logic [COMMAND_SIZE-1:0] command_to_top;
    logic [DATA_SIZE-1:0]    data_to_top;
    logic [CH_SIZE-1:0]      key_to_top;
    logic                    occupied;

    int compared;
    int mismatched;

    // Reference model of the leaf: what it stores and what it last answered
    logic [23:0] m_center;
    int          m_axis;
    bit          m_occ;
    logic [4:0]  m_cmd;
    logic [23:0] m_data;
    logic [7:0]  m_key;

    kd_leaf_responder dut (
        .clk              (clk),
        .reset            (reset),
        .command_from_top (command_from_top),
        .data_from_top    (data_from_top),
        .command_to_top   (command_to_top),
        .data_to_top      (data_to_top),
        .key_to_top       (key_to_top),
        .occupied         (occupied)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update: one parent command (or reset) applied to the abstract leaf
    task automatic model_apply(input logic rn, input logic [4:0] c, input logic [23:0] d);
        if (!rn) begin
            m_center = 24'h0; m_axis = 0; m_occ = 0;
            m_cmd = CMD_NOP; m_data = 24'h0;
        end else begin
            m_cmd = CMD_NOP;
            if (c == CMD_RST) begin
                m_center = 24'h0; m_axis = 0; m_occ = 0;
                m_cmd = CMD_RST_DONE; m_data = 24'h0;
            end else if (c == CMD_CENTER_FILL) begin
                if (!m_occ) begin
                    m_center = d; m_occ = 1; m_cmd = CMD_RECEIVE_CENTER;
                end else m_cmd = CMD_CENTER_FILL_DONE;
            end else if (c == CMD_CONFIGURE_SORT_AXIS) begin
                if (d[1:0] == 2'd3) m_cmd = CMD_DNE;
                else begin
                    m_axis = int'(d[1:0]); m_cmd = CMD_CONFIGURE_SORT_AXIS_DONE;
                end
            end else if (c == CMD_EXPOSE_CENTER) begin
                if (m_occ) begin m_data = m_center; m_cmd = CMD_VALID_SORT; end
                else begin m_data = 24'h0; m_cmd = CMD_DNE; end
            end else if (c == CMD_SWITCH || c == CMD_SWITCH_WITH_LEFT) begin
                if (m_occ) begin
                    m_data = m_center; m_center = d; m_cmd = CMD_VALID_DONE;
                end else m_cmd = CMD_DNE;
            end else if (c == CMD_START_SORTING || c == CMD_START_SORTING_AS_ROOT ||
                         c == CMD_NEXT_SORT_LEVEL) begin
                m_cmd = CMD_SORT_DONE;
            end
        end
        m_key = 8'((m_center >> (16 - 8 * m_axis)) & 24'hFF);
    endtask

    // Present one command for one clock edge, then settle just past the edge
    task automatic drive(input logic rn, input logic [4:0] c, input logic [23:0] d);
        reset            = rn;
        command_from_top = c;
        data_from_top    = d;
        model_apply(rn, c, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, CMD_NOP, 24'h0);
        drive(1'b0, CMD_CENTER_FILL, 24'h123456);
        compared += 3;
        if (command_to_top !== CMD_NOP) begin
            mismatched++; $display("[TB] FAIL reset_cmd got %h want %h", command_to_top, CMD_NOP);
        end
        if (occupied !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_occ got %b want 0", occupied);
        end
        if (data_to_top !== 24'h0 || key_to_top !== 8'h0) begin
            mismatched++; $display("[TB] FAIL reset_data got %h/%h want 0/0", data_to_top, key_to_top);
        end
        drive(1'b1, CMD_RST, 24'hFFFFFF);
        compared += 2;
        if (command_to_top !== CMD_RST_DONE) begin
            mismatched++; $display("[TB] FAIL rst_cmd got %h want %h", command_to_top, CMD_RST_DONE);
        end
        if (data_to_top !== 24'h0) begin
            mismatched++; $display("[TB] FAIL rst_data got %h want 0", data_to_top);
        end
    endtask

    task automatic test_center_fill();
        drive(1'b1, CMD_CENTER_FILL, 24'hA0B0C0);
        compared += 3;
        if (command_to_top !== CMD_RECEIVE_CENTER) begin
            mismatched++; $display("[TB] FAIL fill1_cmd got %h want %h", command_to_top, CMD_RECEIVE_CENTER);
        end
        if (occupied !== 1'b1) begin
            mismatched++; $display("[TB] FAIL fill1_occ got %b want 1", occupied);
        end
        if (key_to_top !== 8'hA0) begin
            mismatched++; $display("[TB] FAIL fill1_key got %h want a0", key_to_top);
        end
        drive(1'b1, CMD_CENTER_FILL, 24'h112233);
        compared++;
        if (command_to_top !== CMD_CENTER_FILL_DONE) begin
            mismatched++; $display("[TB] FAIL fill2_cmd got %h want %h", command_to_top, CMD_CENTER_FILL_DONE);
        end
        drive(1'b1, CMD_EXPOSE_CENTER, 24'h0);
        compared += 2;
        if (data_to_top !== 24'hA0B0C0) begin
            mismatched++; $display("[TB] FAIL expose_data got %h want a0b0c0", data_to_top);
        end
        if (command_to_top !== CMD_VALID_SORT) begin
            mismatched++; $display("[TB] FAIL expose_cmd got %h want %h", command_to_top, CMD_VALID_SORT);
        end
    endtask

    task automatic test_configure_axis();
        drive(1'b1, CMD_CONFIGURE_SORT_AXIS, 24'd1);
        compared += 2;
        if (command_to_top !== CMD_CONFIGURE_SORT_AXIS_DONE) begin
            mismatched++; $display("[TB] FAIL axis1_cmd got %h want %h", command_to_top, CMD_CONFIGURE_SORT_AXIS_DONE);
        end
        if (key_to_top !== 8'hB0) begin
            mismatched++; $display("[TB] FAIL axis1_key got %h want b0", key_to_top);
        end
        drive(1'b1, CMD_CONFIGURE_SORT_AXIS, 24'd3);
        compared += 2;
        if (command_to_top !== CMD_DNE) begin
            mismatched++; $display("[TB] FAIL axis3_cmd got %h want %h", command_to_top, CMD_DNE);
        end
        if (key_to_top !== 8'hB0) begin
            mismatched++; $display("[TB] FAIL axis3_key got %h want b0", key_to_top);
        end
    endtask

    task automatic test_switch();
        drive(1'b1, CMD_SWITCH, 24'h010203);
        compared += 3;
        if (data_to_top !== 24'hA0B0C0) begin
            mismatched++; $display("[TB] FAIL switch_data got %h want a0b0c0", data_to_top);
        end
        if (command_to_top !== CMD_VALID_DONE) begin
            mismatched++; $display("[TB] FAIL switch_cmd got %h want %h", command_to_top, CMD_VALID_DONE);
        end
        if (key_to_top !== 8'h02) begin
            mismatched++; $display("[TB] FAIL switch_key got %h want 02", key_to_top);
        end
        drive(1'b1, CMD_EXPOSE_CENTER, 24'h0);
        compared += 2;
        if (data_to_top !== 24'h010203) begin
            mismatched++; $display("[TB] FAIL switch_expose got %h want 010203", data_to_top);
        end
        if (key_to_top !== 8'h02) begin
            mismatched++; $display("[TB] FAIL switch_expose_key got %h want 02", key_to_top);
        end
    endtask

    task automatic test_empty();
        drive(1'b1, CMD_RST, 24'h0);
        drive(1'b1, CMD_SWITCH, 24'h777777);
        compared++;
        if (command_to_top !== CMD_DNE) begin
            mismatched++; $display("[TB] FAIL empty_switch got %h want %h", command_to_top, CMD_DNE);
        end
        drive(1'b1, CMD_EXPOSE_CENTER, 24'h0);
        compared += 2;
        if (command_to_top !== CMD_DNE) begin
            mismatched++; $display("[TB] FAIL empty_expose got %h want %h", command_to_top, CMD_DNE);
        end
        if (data_to_top !== 24'h0) begin
            mismatched++; $display("[TB] FAIL empty_expose_data got %h want 0", data_to_top);
        end
        drive(1'b1, CMD_START_SORTING, 24'h0);
        compared += 2;
        if (command_to_top !== CMD_SORT_DONE) begin
            mismatched++; $display("[TB] FAIL empty_sort got %h want %h", command_to_top, CMD_SORT_DONE);
        end
        if (occupied !== 1'b0) begin
            mismatched++; $display("[TB] FAIL empty_occ got %b want 0", occupied);
        end
        // Still idle: a fill must be accepted
        drive(1'b1, CMD_CENTER_FILL, 24'h445566);
        compared++;
        if (command_to_top !== CMD_RECEIVE_CENTER) begin
            mismatched++; $display("[TB] FAIL empty_idle got %h want %h", command_to_top, CMD_RECEIVE_CENTER);
        end
    endtask

    task automatic test_sorted_rst();
        drive(1'b1, CMD_START_SORTING_AS_ROOT, 24'h0);
        drive(1'b1, CMD_RST, 24'h0);
        compared += 2;
        if (command_to_top !== CMD_RST_DONE) begin
            mismatched++; $display("[TB] FAIL sorted_rst_cmd got %h want %h", command_to_top, CMD_RST_DONE);
        end
        if (occupied !== 1'b0) begin
            mismatched++; $display("[TB] FAIL sorted_rst_occ got %b want 0", occupied);
        end
        drive(1'b1, CMD_EXPOSE_CENTER, 24'h0);
        compared++;
        if (command_to_top !== CMD_DNE || data_to_top !== 24'h0 || key_to_top !== 8'h0) begin
            mismatched++;
            $display("[TB] FAIL sorted_rst_center got %h/%h/%h want %h/0/0",
                     command_to_top, data_to_top, key_to_top, CMD_DNE);
        end
    endtask

    task automatic test_reset_mid_fill();
        drive(1'b1, CMD_CENTER_FILL, 24'hABCDEF);
        drive(1'b1, CMD_NEXT_SORT_LEVEL, 24'h0);
        drive(1'b0, CMD_CENTER_FILL, 24'h135790);
        compared++;
        if (command_to_top !== CMD_NOP || data_to_top !== 24'h0 ||
            key_to_top !== 8'h0 || occupied !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midfill_reset got %h/%h/%h/%b want 00/0/0/0",
                     command_to_top, data_to_top, key_to_top, occupied);
        end
    endtask

    // Back-to-back: a held command keeps producing the same response
    task automatic test_back_to_back();
        drive(1'b1, CMD_CENTER_FILL, 24'h0F1E2D);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, CMD_EXPOSE_CENTER, 24'h0);
            compared++;
            if (command_to_top !== CMD_VALID_SORT || data_to_top !== 24'h0F1E2D) begin
                mismatched++;
                $display("[TB] FAIL hold_expose[%0d] got %h/%h want %h/0f1e2d",
                         i, command_to_top, data_to_top, CMD_VALID_SORT);
            end
        end
    endtask

    function automatic logic [4:0] pick_cmd(input int idx);
        case (idx)
            0, 1:    return CMD_CENTER_FILL;
            2:       return CMD_CONFIGURE_SORT_AXIS;
            3, 4:    return CMD_EXPOSE_CENTER;
            5:       return CMD_SWITCH;
            6:       return CMD_SWITCH_WITH_LEFT;
            7:       return CMD_START_SORTING;
            8:       return CMD_START_SORTING_AS_ROOT;
            9:       return CMD_NEXT_SORT_LEVEL;
            10:      return CMD_NOP;
            11:      return CMD_RST;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic test_random();
        logic       rn;
        logic [4:0] c;
        logic [23:0] d;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 39) != 0);
            c  = pick_cmd(int'($urandom_range(0, 13)));
            d  = 24'($urandom);
            drive(rn, c, d);
            compared += 4;
            if (command_to_top !== m_cmd) begin
                mismatched++; $display("[TB] FAIL rand_cmd[%0d] got %h want %h", i, command_to_top, m_cmd);
            end
            if (data_to_top !== m_data) begin
                mismatched++; $display("[TB] FAIL rand_data[%0d] got %h want %h", i, data_to_top, m_data);
            end
            if (key_to_top !== m_key) begin
                mismatched++; $display("[TB] FAIL rand_key[%0d] got %h want %h", i, key_to_top, m_key);
            end
            if (occupied !== m_occ) begin
                mismatched++; $display("[TB] FAIL rand_occ[%0d] got %b want %b", i, occupied, m_occ);
            end
        end
    endtask

    // Scenario sequence; each task leaves the leaf in the state the next expects
    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b0;
        command_from_top = CMD_NOP;
        data_from_top = 24'h0;
        model_apply(1'b0, CMD_NOP, 24'h0);
        @(negedge clk);
        test_reset();
        test_center_fill();
        test_configure_axis();
        test_switch();
        test_empty();
        test_sorted_rst();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
